// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one 8-digit seven-segment display driver between four requesters.
// The display is granted to one requester at a time in round-robin order.
// Each grant lasts at least MIN_DWELL cycles. An owner that keeps requesting
// is pre-empted after MAX_DWELL cycles, but only if someone else is waiting.
// The owner's value/enable/point are forwarded to the driver through
// registered outputs.
//
// Ports
//   clock       in   system clock; all state changes on the rising edge
//   reset       in   asynchronous, active-high
//   req         in   [3:0]   level request per requester
//   req_value   in   [127:0] requester k digit nibbles at [32k+31:32k]
//   req_enable  in   [31:0]  requester k digit enables at [8k+7:8k]
//   req_point   in   [31:0]  requester k radix points at [8k+7:8k]
//   grant       out  [3:0]   one-hot current owner, 0 when idle
//   owner       out  [1:0]   encoded owner index, meaningful while busy
//   busy        out          1 while a grant is held
//   value       out  [31:0]  to display driver
//   enable      out  [7:0]   to display driver
//   point       out  [7:0]   to display driver
// -----------------------------------------------------------------------------
module display_arbiter #(
    parameter int MIN_DWELL = 16384,
    parameter int MAX_DWELL = 1048576
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] req_value,
    input  logic [31:0]  req_enable,
    input  logic [31:0]  req_point,
    output logic [3:0]   grant,
    output logic [1:0]   owner,
    output logic         busy,
    output logic [31:0]  value,
    output logic [7:0]   enable,
    output logic [7:0]   point
);

    localparam int CW = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CW-1:0] MIN_LAST = CW'(MIN_DWELL - 1);
    localparam logic [CW-1:0] MAX_LAST = CW'(MAX_DWELL - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t        state_q,  state_d;
    logic [1:0]    own_q,    own_d;
    logic [1:0]    ptr_q,    ptr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [3:0]    grant_q,  grant_d;
    logic          busy_q,   busy_d;
    logic [31:0]   value_q,  value_d;
    logic [7:0]    enable_q, enable_d;
    logic [7:0]    point_q,  point_d;

    // Round-robin search: first set bit of r, scanning start, start+1, ... mod 4.
    // Returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic       found;
        logic [1:0] win;
        logic [1:0] idx;
        found = 1'b0;
        win   = start;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [3:0] own_oh;
    logic [3:0] cand;
    logic       found;
    logic [1:0] win;
    logic       own_req;
    logic       dwell_met;
    logic       dwell_max;
    logic       take;
    logic       release_own;

    assign own_oh = 4'b0001 << own_q;
    // While owned, the current owner is never a handover candidate; since the
    // pointer already sits at owner+1 the scan covers owner+1..owner+3.
    assign cand      = (state_q == ST_OWNED) ? (req & ~own_oh) : req;
    assign {found, win} = rr_pick(cand, ptr_q);
    assign own_req   = req[own_q];
    assign dwell_met = (cnt_q >= MIN_LAST);
    assign dwell_max = (cnt_q >= MAX_LAST);

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        value_d     = value_q;
        enable_d    = enable_q;
        point_d     = point_q;
        take        = 1'b0;
        release_own = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    take = 1'b1;
                end else begin
                    enable_d = '0;
                end
            end
            ST_OWNED: begin
                if (cnt_q != MAX_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Owner data is tracked only while the owner still requests;
                // otherwise the display keeps its last picture.
                if (own_req) begin
                    value_d  = req_value[{own_q, 5'b00000} +: 32];
                    enable_d = req_enable[{own_q, 3'b000} +: 8];
                    point_d  = req_point[{own_q, 3'b000} +: 8];
                end
                if (dwell_met && (!own_req || dwell_max)) begin
                    if (found) begin
                        take = 1'b1;
                    end else if (!own_req) begin
                        release_own = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Grant (from idle) or direct handover: grant goes one-hot to one-hot.
        if (take) begin
            state_d  = ST_OWNED;
            own_d    = win;
            ptr_d    = win + 2'd1;
            cnt_d    = '0;
            grant_d  = 4'b0001 << win;
            busy_d   = 1'b1;
            value_d  = req_value[{win, 5'b00000} +: 32];
            enable_d = req_enable[{win, 3'b000} +: 8];
            point_d  = req_point[{win, 3'b000} +: 8];
        end

        if (release_own) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            busy_d   = 1'b0;
            enable_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            own_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
            value_q  <= '0;
            enable_q <= '0;
            point_q  <= '0;
        end else begin
            state_q  <= state_d;
            own_q    <= own_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
            value_q  <= value_d;
            enable_q <= enable_d;
            point_q  <= point_d;
        end
    end

    assign grant  = grant_q;
    assign owner  = own_q;
    assign busy   = busy_q;
    assign value  = value_q;
    assign enable = enable_q;
    assign point  = point_q;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Scoreboard bench for display_arbiter with MIN_DWELL=4, MAX_DWELL=16.
// The driver applies inputs on the falling edge, advances a behavioural model
// of the arbiter (owner index, cycles owned, round-robin pointer) and pushes
// the expected outputs for the coming rising edge. A separate monitor pops one
// entry per cycle just after the rising edge and compares.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

    localparam int MIN = 4;
    localparam int MAX = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   req = '0;
    logic [127:0] req_value = '0;
    logic [31:0]  req_enable = '0;
    logic [31:0]  req_point = '0;
    logic [3:0]   grant;
    logic [1:0]   owner;
    logic         busy;
    logic [31:0]  value;
    logic [7:0]   enable;
    logic [7:0]   point;

    display_arbiter #(.MIN_DWELL(MIN), .MAX_DWELL(MAX)) dut (
        .clock(clock), .reset(reset), .req(req),
        .req_value(req_value), .req_enable(req_enable), .req_point(req_point),
        .grant(grant), .owner(owner), .busy(busy),
        .value(value), .enable(enable), .point(point)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  g;
        logic [1:0]  o;
        logic        b;
        logic [31:0] v;
        logic [7:0]  e;
        logic [7:0]  p;
        bit          co;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   started = 0;
    bit   stopping = 0;

    // Behavioural model state: m_own = -1 when nobody holds the display,
    // m_age = number of edges the current owner has already held it.
    int          m_own = -1;
    int          m_ptr = 0;
    int          m_age = 0;
    logic [3:0]  e_g = '0;
    logic [1:0]  e_o = '0;
    logic        e_b = 1'b0;
    logic [31:0] e_v = '0;
    logic [7:0]  e_e = '0;
    logic [7:0]  e_p = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int start, input int excl);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (start + i) % 4;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    task automatic load(input int k);
        e_v = req_value[32*k +: 32];
        e_e = req_enable[8*k +: 8];
        e_p = req_point[8*k +: 8];
    endtask

    task automatic take(input int w);
        m_own = w;
        m_ptr = (w + 1) % 4;
        m_age = 0;
        e_g   = 4'(1 << w);
        e_o   = 2'(w);
        e_b   = 1'b1;
        load(w);
    endtask

    // Outcome of the next rising edge given the inputs currently driven.
    task automatic model_step();
        int   w;
        int   c;
        exp_t x;
        if (reset) begin
            m_own = -1; m_ptr = 0; m_age = 0;
            e_g = '0; e_o = '0; e_b = 1'b0; e_v = '0; e_e = '0; e_p = '0;
        end else if (m_own < 0) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) take(w);
            else e_e = '0;
        end else begin
            c = (m_age < MAX - 1) ? m_age : MAX - 1;
            w = pick(req, m_own + 1, m_own);
            if (req[m_own]) load(m_own);
            if (c >= MIN - 1 && !req[m_own] && w >= 0) begin
                take(w);
            end else if (c >= MIN - 1 && !req[m_own]) begin
                m_own = -1;
                e_g = '0; e_b = 1'b0; e_e = '0;
            end else if (req[m_own] && c >= MAX - 1 && w >= 0) begin
                take(w);
            end else if (m_age < 1000) begin
                m_age++;
            end
        end
        x.g = e_g; x.o = e_o; x.b = e_b; x.v = e_v; x.e = e_e; x.p = e_p;
        x.co = e_b || reset;
        q.push_back(x);
        started = 1;
    endtask

    task automatic rnd_data();
        req_value  = {$urandom, $urandom, $urandom, $urandom};
        req_enable = $urandom;
        req_point  = $urandom;
    endtask

    task automatic cyc(input logic [3:0] r, input bit rnd);
        @(negedge clock);
        req = r;
        if (rnd) rnd_data();
        model_step();
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_value", value, 32'h0);
        chk("async_enable", 32'(enable), 32'h0);
        model_step();
        for (int i = 1; i < n; i++) begin
            @(negedge clock);
            model_step();
        end
        @(negedge clock);
        reset = 1'b0;
        req   = '0;
        model_step();
    endtask

    // Monitor: one expected entry per rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("grant", 32'(grant), 32'(x.g));
                chk("busy", 32'(busy), 32'(x.b));
                chk("value", value, x.v);
                chk("enable", 32'(enable), 32'(x.e));
                chk("point", 32'(point), 32'(x.p));
                if (x.co) chk("owner", 32'(owner), 32'(x.o));
            end else if (started && !stopping) begin
                chk("scoreboard_empty", 32'(q.size()), 32'd1);
            end
        end
    end

    initial begin
        logic [3:0] r;

        // Reset, single requester, reset mid-grant, single requester again
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_step();
        @(negedge clock);
        rnd_data();
        req_value[95:64] = 32'h12345678;
        req = 4'b0100;
        model_step();
        for (int i = 0; i < 3; i++) cyc(4'b0100, 0);
        do_reset(2);
        @(negedge clock);
        rnd_data();
        req_value[95:64] = 32'h12345678;
        req = 4'b0100;
        model_step();
        for (int i = 0; i < 5; i++) cyc(4'b0100, 1);

        // Simultaneous requests from idle: 0, 1, 2, 3 in turn
        do_reset(1);
        for (int i = 0; i < 70; i++) cyc(4'b1111, 1);

        // Early drop by owner 1
        do_reset(1);
        cyc(4'b0010, 1);
        for (int i = 0; i < 8; i++) cyc(4'b0000, 1);

        // Handover after minimum dwell: 0 holds 10 cycles, 3 waiting
        do_reset(1);
        for (int i = 0; i < 10; i++) cyc(4'b1001, 1);
        for (int i = 0; i < 8; i++) cyc(4'b1000, 1);

        // Saturating sole owner
        do_reset(1);
        for (int i = 0; i < 100; i++) cyc(4'b0010, 1);

        // Pre-emption and rotation between 0 and 1
        do_reset(1);
        for (int i = 0; i < 80; i++) cyc(4'b0011, 1);

        // Random request patterns with occasional mid-run reset
        do_reset(1);
        r = '0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            end
            if (i == 300) do_reset(2);
            cyc(r, 1);
        end

        stopping = 1;
        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
